// File: rtl/router_out_arb_if.sv
// Handshake bundle between the router input ports and one output-port
// arbiter: input flits with valid/request, per-input backpressure, the
// registered output flit with its valid/header flags, and the grant vector.
interface router_out_arb_if #(
   parameter int NPORT = 4,
   parameter int WIDTH = 64
);
   logic [NPORT-1:0][WIDTH-1:0] D;
   logic [NPORT-1:0]            D_VALID;
   logic [NPORT-1:0]            REQ;
   logic [NPORT-1:0]            D_BP;
   logic [WIDTH-1:0]            Q;
   logic                        Q_VALID;
   logic                        Q_SOF;
   logic                        Q_BP;
   logic [NPORT-1:0]            GRANT;

   // Router side: drives the inputs and downstream backpressure.
   modport master (
      output D, D_VALID, REQ, Q_BP,
      input  D_BP, Q, Q_VALID, Q_SOF, GRANT
   );

   // Arbiter side.
   modport slave (
      input  D, D_VALID, REQ, Q_BP,
      output D_BP, Q, Q_VALID, Q_SOF, GRANT
   );
endinterface

// File: rtl/router_out_arb.sv
// Packet-level round-robin arbiter and output mux for one router output.
// An input is granted for a whole packet (a contiguous run of valid flits);
// its flits pass through one registered output stage. The round-robin
// pointer moves to the input after the one that just finished.
// Optional statistics counters are built when ROUTER_ARB_STATS_EN is defined.
module router_out_arb #(
   parameter int NPORT = 4,
   parameter int WIDTH = 64
) (
   input  logic                   CLK,
   input  logic                   RST,
   router_out_arb_if.slave        bus
`ifdef ROUTER_ARB_STATS_EN
   ,
   output logic [NPORT-1:0][31:0] PKT_CNT,
   output logic [31:0]            FLIT_CNT
`endif
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    gidx_q, gidx_d;
   logic [NPORT-1:0] grant_q, grant_d;
   logic [NPORT-1:0] cand;
   logic [NPORT-1:0] dbp;
   logic             win_found;
   logic [PW-1:0]    win_idx;
   logic [PW-1:0]    gidx_inc;
   logic             take_grant;
   logic [WIDTH-1:0] q_p1, q_d;
   logic             vld_p1, vld_d;
   logic             sof_p1, sof_d;

   assign cand     = bus.D_VALID & bus.REQ;
   assign gidx_inc = (gidx_q == PW'(NPORT - 1)) ? '0 : gidx_q + PW'(1);

   // Round-robin search: first candidate at or after the pointer, wrapping.
   always_comb begin
      logic [PW-1:0] ix;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NPORT; k++) begin
         ix = PW'((int'(ptr_q) + k) % NPORT);
         if (!win_found && cand[ix]) begin
            win_found = 1'b1;
            win_idx   = ix;
         end
      end
   end

   // Next-state and output-stage load decisions; Q_BP freezes everything.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      grant_d    = grant_q;
      q_d        = q_p1;
      vld_d      = vld_p1;
      sof_d      = sof_p1;
      take_grant = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.Q_BP) begin
               if (win_found) begin
                  state_d    = BUSY;
                  gidx_d     = win_idx;
                  grant_d    = NPORT'(1) << win_idx;
                  q_d        = bus.D[win_idx];
                  vld_d      = 1'b1;
                  sof_d      = 1'b1;
                  take_grant = 1'b1;
               end else begin
                  vld_d = 1'b0;
                  sof_d = 1'b0;
               end
            end
         end
         BUSY: begin
            if (!bus.Q_BP) begin
               if (bus.D_VALID[gidx_q]) begin
                  q_d   = bus.D[gidx_q];
                  vld_d = 1'b1;
                  sof_d = 1'b0;
               end else begin
                  // Valid dropped on the owner: packet is over.
                  vld_d   = 1'b0;
                  sof_d   = 1'b0;
                  grant_d = '0;
                  ptr_d   = gidx_inc;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Backpressure: owner follows downstream, other contenders are held.
   always_comb begin
      dbp = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (state_q == BUSY) begin
            dbp[i] = (PW'(i) == gidx_q) ? bus.Q_BP : bus.D_VALID[i];
         end else begin
            dbp[i] = (win_found && PW'(i) == win_idx) ? bus.Q_BP : cand[i];
         end
      end
   end

   // State, pointer, grant and the registered output stage.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         q_p1    <= '0;
         vld_p1  <= 1'b0;
         sof_p1  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         q_p1    <= q_d;
         vld_p1  <= vld_d;
         sof_p1  <= sof_d;
      end
   end

   assign bus.D_BP    = dbp;
   assign bus.Q       = q_p1;
   assign bus.Q_VALID = vld_p1;
   assign bus.Q_SOF   = sof_p1;
   assign bus.GRANT   = grant_q;

`ifdef ROUTER_ARB_STATS_EN
   // Per-input grant counts and accepted output flit count, both wrapping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         PKT_CNT  <= '0;
         FLIT_CNT <= '0;
      end else begin
         if (take_grant) begin
            PKT_CNT[win_idx] <= PKT_CNT[win_idx] + 32'd1;
         end
         if (vld_p1 && !bus.Q_BP) begin
            FLIT_CNT <= FLIT_CNT + 32'd1;
         end
      end
   end
`endif

endmodule
